dtc_therm_window_decoder: RTL and testbench

Consumer end of the classifier output interface. Accepts thermometer-coded class levels from a dtc classifier over a valid/ready stream and decodes each one to a binary level with a code-error flag. It aggregates a fixed window of samples into a summary of sum, min, max and error count. The summary is emitted on a second valid/ready handshake towards the scoring/telemetry logic.

---
 rtl/dtc_therm_window_decoder_if.sv | 37 +++
 rtl/dtc_therm_window_decoder.sv | 123 ++++++++++++
 tb/tb_dtc_therm_window_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dtc_therm_window_decoder_if.sv
// Sample stream in, per-sample level and window summary out.
// master drives samples and summary ready; slave is the decoder.
interface dtc_therm_window_decoder_if #(
  parameter int WIDTH = 10,
  parameter int WIN   = 16
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIN);
  localparam int SW = LW + CW;
  localparam int EW = $clog2(WIN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_code;
  logic             flush;
  logic             lvl_valid;
  logic [LW-1:0]    lvl;
  logic             lvl_err;
  logic             sum_valid;
  logic             sum_ready;
  logic [SW-1:0]    sum_total;
  logic [LW-1:0]    sum_min;
  logic [LW-1:0]    sum_max;
  logic [EW-1:0]    sum_errs;

  modport master (
    output in_valid, in_code, flush, sum_ready,
    input  in_ready, lvl_valid, lvl, lvl_err,
    input  sum_valid, sum_total, sum_min, sum_max, sum_errs
  );

  modport slave (
    input  in_valid, in_code, flush, sum_ready,
    output in_ready, lvl_valid, lvl, lvl_err,
    output sum_valid, sum_total, sum_min, sum_max, sum_errs
  );
endinterface

// File: rtl/dtc_therm_window_decoder.sv
// Thermometer level decoder with windowed sum/min/max/error summary.
// Summary leaves on a valid/ready handshake; final sample waits for it.
module dtc_therm_window_decoder #(
  parameter int WIDTH = 10,
  parameter int WIN   = 16
) (
  input logic clk,
  input logic rst_n,
  dtc_therm_window_decoder_if.slave bus
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIN);
  localparam int SW = LW + CW;
  localparam int EW = $clog2(WIN + 1);

  typedef enum logic {ACCUM, PEND} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] acc_sum_q;
  logic [LW-1:0] acc_min_q;
  logic [LW-1:0] acc_max_q;
  logic [EW-1:0] acc_err_q;
  logic          lvl_valid_q;
  logic [LW-1:0] lvl_q;
  logic          lvl_err_q;
  logic [SW-1:0] sum_total_q;
  logic [LW-1:0] sum_min_q;
  logic [LW-1:0] sum_max_q;
  logic [EW-1:0] sum_errs_q;

  logic [LW-1:0] lvl_d;
  logic          err_d;
  logic          found;
  logic          last;
  logic          accept;
  logic [SW-1:0] sum_d;
  logic [LW-1:0] min_d;
  logic [LW-1:0] max_d;
  logic [EW-1:0] errs_d;

  // Lowest zero bit gives the level; any set bit at or above it is illegal.
  always_comb begin
    lvl_d = LW'(WIDTH);
    err_d = 1'b0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (found && bus.in_code[i])
        err_d = 1'b1;
      if (!found && !bus.in_code[i]) begin
        lvl_d = LW'(i);
        found = 1'b1;
      end
    end
  end

  assign last   = (cnt_q == CW'(WIN - 1));
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready = !bus.flush &&
    (state_q == ACCUM || bus.sum_ready || !last);

  assign sum_d  = acc_sum_q + SW'(lvl_d);
  assign min_d  = (lvl_d < acc_min_q) ? lvl_d : acc_min_q;
  assign max_d  = (lvl_d > acc_max_q) ? lvl_d : acc_max_q;
  assign errs_d = acc_err_q + EW'(err_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_sum_q   <= '0;
      acc_min_q   <= LW'(WIDTH);
      acc_max_q   <= '0;
      acc_err_q   <= '0;
      lvl_valid_q <= 1'b0;
      lvl_q       <= '0;
      lvl_err_q   <= 1'b0;
      sum_total_q <= '0;
      sum_min_q   <= '0;
      sum_max_q   <= '0;
      sum_errs_q  <= '0;
    end else begin
      lvl_valid_q <= accept;
      if (accept) begin
        lvl_q     <= lvl_d;
        lvl_err_q <= err_d;
      end
      if (state_q == PEND && bus.sum_ready)
        state_q <= ACCUM;
      if (bus.flush || (accept && last)) begin
        cnt_q     <= '0;
        acc_sum_q <= '0;
        acc_min_q <= LW'(WIDTH);
        acc_max_q <= '0;
        acc_err_q <= '0;
      end else if (accept) begin
        cnt_q     <= cnt_q + CW'(1);
        acc_sum_q <= sum_d;
        acc_min_q <= min_d;
        acc_max_q <= max_d;
        acc_err_q <= EW'(errs_d);
      end
      // Completion overrides a same-cycle handshake so no summary is lost.
      if (accept && last) begin
        state_q     <= PEND;
        sum_total_q <= sum_d;
        sum_min_q   <= min_d;
        sum_max_q   <= max_d;
        sum_errs_q  <= errs_d;
      end
    end
  end

  assign bus.lvl_valid = lvl_valid_q;
  assign bus.lvl       = lvl_q;
  assign bus.lvl_err   = lvl_err_q;
  assign bus.sum_valid = (state_q == PEND);
  assign bus.sum_total = sum_total_q;
  assign bus.sum_min   = sum_min_q;
  assign bus.sum_max   = sum_max_q;
  assign bus.sum_errs  = sum_errs_q;
endmodule

// File: tb/tb_dtc_therm_window_decoder.sv
// Directed bench for dtc_therm_window_decoder.
// Expected decodes and summaries are queued at drive time, popped at output.
module tb_dtc_therm_window_decoder;
  localparam int WIDTH = 10;
  localparam int WIN   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtc_therm_window_decoder_if #(.WIDTH(WIDTH), .WIN(WIN)) bus ();

  dtc_therm_window_decoder #(.WIDTH(WIDTH), .WIN(WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int lv;
    int er;
  } lexp_t;

  typedef struct {
    int t;
    int mn;
    int mx;
    int e;
  } sexp_t;

  int total = 0;
  int bad   = 0;

  lexp_t lq[$];
  sexp_t sq[$];
  sexp_t cur_sum;

  int m_cnt, m_sum, m_min, m_max, m_err;
  bit m_sv;
  int last_lvl, last_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] therm(int k);
    return WIDTH'((1 << k) - 1);
  endfunction

  // Level = run of ones from bit 0; legal only if code is exactly that run.
  task automatic ref_decode(input logic [WIDTH-1:0] code,
                            output int lv, output int er);
    lv = 0;
    while (lv < WIDTH && code[lv] === 1'b1) lv++;
    er = (int'(code) != ((1 << lv) - 1)) ? 1 : 0;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_sum = 0;
    m_min = WIDTH;
    m_max = 0;
    m_err = 0;
  endtask

  task automatic step(bit v, logic [WIDTH-1:0] code, bit fl, bit sr);
    int lv, er;
    bit rdy, acc;
    lexp_t le;
    bus.in_valid  = v;
    bus.in_code   = code;
    bus.flush     = fl;
    bus.sum_ready = sr;
    #1;
    rdy = !fl && (!m_sv || sr || m_cnt != WIN - 1);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    acc = v && rdy;
    ref_decode(code, lv, er);
    if (m_sv && sr) m_sv = 0;
    if (fl) begin
      model_clear();
    end else if (acc) begin
      lq.push_back('{lv, er});
      if (m_cnt == WIN - 1) begin
        sq.push_back('{m_sum + lv,
                       (lv < m_min) ? lv : m_min,
                       (lv > m_max) ? lv : m_max,
                       m_err + er});
        m_sv = 1;
        model_clear();
      end else begin
        m_cnt++;
        m_sum += lv;
        if (lv < m_min) m_min = lv;
        if (lv > m_max) m_max = lv;
        m_err += er;
      end
    end
    @(posedge clk);
    #1;
    chk("lvl_valid", 32'(bus.lvl_valid), 32'(acc));
    if (acc) begin
      le = lq.pop_front();
      last_lvl = le.lv;
      last_err = le.er;
    end
    chk("lvl", 32'(bus.lvl), 32'(last_lvl));
    chk("lvl_err", 32'(bus.lvl_err), 32'(last_err));
    chk("sum_valid", 32'(bus.sum_valid), 32'(m_sv));
    if (sq.size() != 0) cur_sum = sq.pop_front();
    if (m_sv) begin
      chk("sum_total", 32'(bus.sum_total), 32'(cur_sum.t));
      chk("sum_min", 32'(bus.sum_min), 32'(cur_sum.mn));
      chk("sum_max", 32'(bus.sum_max), 32'(cur_sum.mx));
      chk("sum_errs", 32'(bus.sum_errs), 32'(cur_sum.e));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] bad1, bad2, bad3;
    bad1 = 10'b0000110111;
    bad2 = 10'b1000000000;
    bad3 = 10'b0101010101;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.flush     = 1'b0;
    bus.sum_ready = 1'b0;
    model_clear();
    m_sv = 0;
    last_lvl = 0;
    last_err = 0;
    cur_sum = '{0, 0, 0, 0};
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_lvl_valid", 32'(bus.lvl_valid), 32'd0);
    chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
    chk("rst_sum_total", 32'(bus.sum_total), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // decode sweep
    for (int k = 0; k <= WIDTH; k++) step(1, therm(k), 0, 1);
    step(1, bad1, 0, 1);
    step(1, bad2, 0, 1);
    step(0, '0, 0, 1);
    chk("sweep_lvl_hold", 32'(bus.lvl), 32'd0);
    step(0, '0, 1, 1);

    // alternating 8/5 window
    for (int i = 0; i < WIN; i++)
      step(1, therm((i % 2 == 0) ? 8 : 5), 0, 1);
    chk("alt_total_104", 32'(bus.sum_total), 32'd104);
    step(0, '0, 0, 1);

    // backpressure across two windows
    for (int i = 0; i < WIN; i++) step(1, therm(7), 0, 0);
    for (int i = 0; i < WIN - 1; i++) step(1, therm(2), 0, 0);
    step(1, therm(3), 0, 0);
    step(1, therm(3), 0, 0);
    step(1, therm(3), 0, 1);
    step(0, '0, 0, 0);
    chk("bp_total_w2", 32'(bus.sum_total), 32'd33);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    // flush a partial window
    for (int i = 0; i < 5; i++) step(1, therm(i + 1), 0, 1);
    step(1, therm(9), 1, 1);
    for (int i = 0; i < WIN; i++) step(1, therm(10), 0, 1);
    chk("flush_total_160", 32'(bus.sum_total), 32'd160);
    step(0, '0, 0, 1);

    // error counting
    for (int i = 0; i < WIN; i++) begin
      if (i == 2) step(1, bad1, 0, 1);
      else if (i == 7) step(1, bad2, 0, 1);
      else if (i == 15) step(1, bad3, 0, 1);
      else step(1, therm(i % 11), 0, 1);
    end
    chk("errs_3", 32'(bus.sum_errs), 32'd3);
    step(0, '0, 0, 1);

    // reset with a pending summary and a partial window
    for (int i = 0; i < WIN; i++) step(1, therm(4), 0, 0);
    for (int i = 0; i < 4; i++) step(1, therm(6), 0, 0);
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_sum_valid", 32'(bus.sum_valid), 32'd0);
    chk("mrst_lvl_valid", 32'(bus.lvl_valid), 32'd0);
    chk("mrst_lvl", 32'(bus.lvl), 32'd0);
    chk("mrst_sum_total", 32'(bus.sum_total), 32'd0);
    chk("mrst_sum_min", 32'(bus.sum_min), 32'd0);
    chk("mrst_sum_max", 32'(bus.sum_max), 32'd0);
    chk("mrst_sum_errs", 32'(bus.sum_errs), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    model_clear();
    m_sv = 0;
    last_lvl = 0;
    last_err = 0;
    lq.delete();
    sq.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < WIN; i++)
      step(1, therm($urandom_range(WIDTH, 0)), 0, 1);
    step(0, '0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
